tmds_encoder: RTL and testbench
===============================

TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 SHALL have no parameters; one instance per TMDS channel.
REQ-002 clk_px  input  1  pixel clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data  input  8  pixel byte; valid only when de=1.
REQ-005 ctrl  input  2  control bits {C1,C0}; used only when de=0.
REQ-006 de  input  1  data enable: 1 = video data period, 0 = control period.
REQ-007 cmd  output  10  registered TMDS symbol; cmd[0] is the first bit on the wire; connects directly to the serializer's cmd input.
REQ-008 disparity  output  5  running disparity counter, signed two's complement; exposed for verification.

Function
REQ-009 SHALL be a fixed 2-stage pipeline: inputs sampled at edge N appear on cmd after edge N+1; no stalls, no handshake, one symbol per clk_px.
REQ-010 Stage 1 SHALL register q_m[8:0], N1(data) and pass-through registers for de and ctrl.
REQ-011 Stage 1 path selection: if N1(data)>4, or N1(data)==4 with data[0]==0, use XNOR; otherwise use XOR.
REQ-012 Stage 1 XNOR path: q_m[0]=data[0]; q_m[i]=~(q_m[i-1]^data[i]) for i=1..7; q_m[8]=0.
REQ-013 Stage 1 XOR path: q_m[0]=data[0]; q_m[i]=q_m[i-1]^data[i] for i=1..7; q_m[8]=1.
REQ-014 Stage 2 SHALL compute N1q and N0q as the ones and zeros counts of q_m[7:0], then register cmd and update disparity.
REQ-015 Stage 2, case A (stage-2 de=1, and disparity==0 or N1q==N0q): cmd[9]=~q_m[8]; cmd[8]=q_m[8]; cmd[7:0]=q_m[8]?q_m[7:0]:~q_m[7:0].
REQ-016 Case A disparity update: disparity += q_m[8] ? (N1q-N0q) : (N0q-N1q).
REQ-017 Stage 2, case B (stage-2 de=1, and either disparity>0 with N1q>N0q, or disparity<0 with N0q>N1q): cmd={1, q_m[8], ~q_m[7:0]}.
REQ-018 Case B disparity update: disparity += 2*q_m[8] + (N0q-N1q).
REQ-019 Stage 2, case C (stage-2 de=1, all other cases): cmd={0, q_m[8], q_m[7:0]}.
REQ-020 Case C disparity update: disparity += (N1q-N0q) - 2*(~q_m[8]).
REQ-021 Control period (stage-2 de=0): cmd SHALL be, by ctrl: 00 -> 10'b1101010100; 01 -> 10'b0010101011; 10 -> 10'b0101010100; 11 -> 10'b1010101011.
REQ-022 Control period: disparity SHALL be set to 0.
REQ-023 Arithmetic SHALL be 5-bit signed; disparity stays in the range -8..+8, even values only, so overflow is impossible.
REQ-024 de transitions SHALL take effect per symbol with no guard insertion; the first data symbol after a control period starts from disparity=0.

Reset
REQ-025 While reset=1, the block SHALL hold cmd=10'b1101010100 (the ctrl=00 control symbol), disparity=0, stage-1 de=0, ctrl=00, q_m=0.
REQ-026 Reset asserted mid-stream SHALL take effect immediately, asynchronous to clk_px.
REQ-027 After reset deasserts, the first valid cmd SHALL reflect inputs sampled at the first edge, appearing one edge later.

Verification
REQ-028 Reset with de=0, ctrl=00 -> cmd=0x354 and disparity=0 during reset and after release.
REQ-029 de=0 with ctrl stepping 00,01,10,11 -> cmd=0x354, 0x0AB, 0x154, 0x2AB, each 2 cycles after its input.
REQ-030 From disparity 0, data=0x00 with de=1 for 3 cycles -> cmd=0x100, 0x3FF, 0x100; disparity=-8, +2, -6.
REQ-031 From disparity 0, data=0xFF with de=1 -> cmd=0x200 and disparity=-8; then de=0 -> disparity returns to 0 and the control symbol is emitted.
REQ-032 Random data with de bursts against a reference model -> cmd matches every cycle; |disparity|<=8; decoding cmd recovers data.
REQ-033 Reset asserted mid-burst -> cmd=0x354 and disparity=0 asynchronously; the stream restarts cleanly after release.

Source files
------------

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b encoder for one channel: stage 1 transition-minimises the byte,
// stage 2 DC-balances it against the running disparity or emits a control symbol.
module tmds_encoder (
    input  logic       clk_px,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    input  logic       de,
    output logic [9:0] cmd,
    output logic [4:0] disparity
);

    typedef enum logic [1:0] {
        SYM_CTRL,
        SYM_BAL,
        SYM_INV,
        SYM_PASS
    } sym_kind_t;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // ---------------- stage 1: transition minimisation ----------------
    logic [3:0] n1_data;
    logic       use_xnor;
    logic [8:0] q_m_next;

    always_comb begin
        n1_data  = ones8(data);
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
        q_m_next = '0;
        q_m_next[0] = data[0];
        for (int unsigned i = 1; i < 8; i++) begin
            q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ data[i])
                                   :  (q_m_next[i-1] ^ data[i]);
        end
        q_m_next[8] = ~use_xnor;
    end

    logic [8:0] q_m_r;
    logic [3:0] n1_data_r;
    logic       de_r;
    logic [1:0] ctrl_r;

    always_ff @(posedge clk_px or posedge reset) begin
        if (reset) begin
            q_m_r     <= '0;
            n1_data_r <= '0;
            de_r      <= 1'b0;
            ctrl_r    <= '0;
        end else begin
            q_m_r     <= q_m_next;
            n1_data_r <= n1_data;
            de_r      <= de;
            ctrl_r    <= ctrl;
        end
    end

    // The registered byte weight must agree with the path stage 1 chose.
    a_path_select: assert property (@(posedge clk_px) disable iff (reset)
        de_r |-> (q_m_r[8] == !((n1_data_r > 4'd4) ||
                                ((n1_data_r == 4'd4) && !q_m_r[0]))));

    // ---------------- stage 2: DC balancing ----------------
    logic signed [4:0] disp_r;
    logic signed [4:0] disp_next;
    logic signed [4:0] diff;
    logic [3:0]        n1q;
    logic              disp_zero;
    logic              disp_neg;
    logic              disp_pos;
    sym_kind_t         kind;
    logic [9:0]        cmd_next;

    always_comb begin
        n1q       = ones8(q_m_r[7:0]);
        // N1q - N0q == 2*N1q - 8, done mod 32 and reinterpreted as signed.
        diff      = $signed({n1q, 1'b0} - 5'd8);
        disp_zero = (disp_r == 5'sd0);
        disp_neg  = disp_r[4];
        disp_pos  = !disp_neg && !disp_zero;

        if (!de_r) begin
            kind = SYM_CTRL;
        end else if (disp_zero || (n1q == 4'd4)) begin
            kind = SYM_BAL;
        end else if ((disp_pos && (n1q > 4'd4)) || (disp_neg && (n1q < 4'd4))) begin
            kind = SYM_INV;
        end else begin
            kind = SYM_PASS;
        end
    end

    always_comb begin
        cmd_next  = CTRL_00;
        disp_next = disp_r;
        unique case (kind)
            SYM_CTRL: begin
                unique case (ctrl_r)
                    2'b00:   cmd_next = CTRL_00;
                    2'b01:   cmd_next = CTRL_01;
                    2'b10:   cmd_next = CTRL_10;
                    default: cmd_next = CTRL_11;
                endcase
                disp_next = 5'sd0;
            end
            SYM_BAL: begin
                cmd_next  = {~q_m_r[8], q_m_r[8],
                             q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
                disp_next = disp_r + (q_m_r[8] ? diff : -diff);
            end
            SYM_INV: begin
                cmd_next  = {1'b1, q_m_r[8], ~q_m_r[7:0]};
                disp_next = disp_r + $signed({3'b000, q_m_r[8], 1'b0}) - diff;
            end
            default: begin
                cmd_next  = {1'b0, q_m_r[8], q_m_r[7:0]};
                disp_next = disp_r + diff - (q_m_r[8] ? 5'sd0 : 5'sd2);
            end
        endcase
    end

    always_ff @(posedge clk_px or posedge reset) begin
        if (reset) begin
            cmd    <= CTRL_00;
            disp_r <= '0;
        end else begin
            cmd    <= cmd_next;
            disp_r <= disp_next;
        end
    end

    assign disparity = disp_r;

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: a driver pushes model-predicted symbols,
// a negedge monitor pops and compares them two edges after issue.
module tb_tmds_encoder;

    logic       clk_px = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] data   = '0;
    logic [1:0] ctrl   = '0;
    logic       de     = 1'b0;
    logic [9:0] cmd;
    logic [4:0] disparity;

    tmds_encoder dut (
        .clk_px   (clk_px),
        .reset    (reset),
        .data     (data),
        .ctrl     (ctrl),
        .de       (de),
        .cmd      (cmd),
        .disparity(disparity)
    );

    always #5 clk_px = ~clk_px;

    typedef struct {
        int         stamp;
        logic [9:0] cmd;
        int         disp;
        logic       de;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   cycle    = 0;
    int   checks   = 0;
    int   failures = 0;
    int   model_disp = 0;

    always @(posedge clk_px) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    // Reference: direct arithmetic on bit counts with an integer disparity.
    task automatic model(input logic d_e, input logic [7:0] d, input logic [1:0] c,
                         inout int disp, output logic [9:0] sym);
        logic [8:0] qm;
        int n1, n1q, n0q;
        bit use_xnor;
        if (!d_e) begin
            case (c)
                2'd0: sym = 10'h354;
                2'd1: sym = 10'h0AB;
                2'd2: sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            disp = 0;
        end else begin
            n1 = ones(d);
            use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int i = 1; i < 8; i++)
                qm[i] = (qm[i-1] ^ d[i]) ^ use_xnor;
            qm[8] = !use_xnor;
            n1q = ones(qm[7:0]);
            n0q = 8 - n1q;
            if (disp == 0 || n1q == n0q) begin
                sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
            end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
                sym = {1'b1, qm[8], ~qm[7:0]};
                disp += 2 * int'(qm[8]) + (n0q - n1q);
            end else begin
                sym = {1'b0, qm[8], qm[7:0]};
                disp += (n1q - n0q) - (qm[8] ? 0 : 2);
            end
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] w, d;
        w = s[9] ? ~s[7:0] : s[7:0];
        d[0] = w[0];
        for (int i = 1; i < 8; i++)
            d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
        return d;
    endfunction

    task automatic issue(input logic d_e, input logic [7:0] d, input logic [1:0] c);
        exp_t e;
        logic [9:0] sym;
        de = d_e; data = d; ctrl = c;
        model(d_e, d, c, model_disp, sym);
        e.stamp = cycle; e.cmd = sym; e.disp = model_disp; e.de = d_e; e.data = d;
        sb.push_back(e);
    endtask

    task automatic drive(input logic d_e, input logic [7:0] d, input logic [1:0] c);
        @(negedge clk_px);
        issue(d_e, d, c);
    endtask

    // Directed step with a hand-derived expectation instead of the model.
    task automatic drive_k(input logic d_e, input logic [7:0] d, input logic [1:0] c,
                           input logic [9:0] exp_cmd, input int exp_disp);
        exp_t e;
        @(negedge clk_px);
        de = d_e; data = d; ctrl = c;
        model_disp = exp_disp;
        e.stamp = cycle; e.cmd = exp_cmd; e.disp = exp_disp; e.de = d_e; e.data = d;
        sb.push_back(e);
    endtask

    always @(negedge clk_px) begin
        if (!reset && sb.size() > 0 && cycle >= sb[0].stamp + 2) begin
            exp_t e;
            int dact;
            e = sb.pop_front();
            dact = int'($signed(disparity));
            check("cmd", int'(cmd), int'(e.cmd));
            check("disparity", dact, e.disp);
            check("disp_range", int'(dact >= -8 && dact <= 8), 1);
            if (e.de) check("decode", int'(decode(cmd)), int'(e.data));
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int burst_left = 0;
        bit in_data = 1'b0;
        logic [7:0] dv;

        repeat (3) @(negedge clk_px);
        check("reset_cmd", int'(cmd), 'h354);
        check("reset_disp", int'(disparity), 0);
        @(negedge clk_px);
        reset = 1'b0;
        issue(1'b0, 8'h00, 2'd0);

        drive_k(1'b0, 8'h00, 2'd0, 10'h354, 0);
        drive_k(1'b0, 8'h00, 2'd1, 10'h0AB, 0);
        drive_k(1'b0, 8'h00, 2'd2, 10'h154, 0);
        drive_k(1'b0, 8'h00, 2'd3, 10'h2AB, 0);
        drive_k(1'b1, 8'h00, 2'd0, 10'h100, -8);
        drive_k(1'b1, 8'h00, 2'd0, 10'h3FF, 2);
        drive_k(1'b1, 8'h00, 2'd0, 10'h100, -6);
        drive_k(1'b0, 8'h00, 2'd0, 10'h354, 0);
        drive_k(1'b1, 8'hFF, 2'd0, 10'h200, -8);
        drive_k(1'b0, 8'h00, 2'd0, 10'h354, 0);

        for (int i = 0; i < 400; i++) begin
            if (burst_left == 0) begin
                in_data = ~in_data;
                burst_left = in_data ? $urandom_range(1, 24) : $urandom_range(1, 4);
            end
            burst_left--;
            case ($urandom_range(0, 7))
                0: dv = 8'h00;
                1: dv = 8'hFF;
                2: dv = 8'h0F;
                default: dv = 8'($urandom);
            endcase
            drive(in_data, dv, 2'($urandom_range(0, 3)));

            if (i == 200) begin
                #3;
                reset = 1'b1;
                sb.delete();
                model_disp = 0;
                #1;
                check("async_reset_cmd", int'(cmd), 'h354);
                check("async_reset_disp", int'(disparity), 0);
                de = 1'b0; ctrl = 2'd0;
                repeat (2) @(negedge clk_px);
                reset = 1'b0;
                issue(1'b0, 8'h00, 2'd0);
            end
        end

        drive(1'b0, 8'h00, 2'd0);
        repeat (4) @(negedge clk_px);
        check("drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
